ptmch_spi_rx: RTL and testbench

//  SPI slave receiver in front of the pattern-match trigger stage. Oversamples SPI_CS/SPI_CLK/SPI_MOSI
//  in the CLK160M domain and deserialises each frame into P_WORD_W-bit words.

---
 rtl/ptmch_pkg.sv | 20 ++
 rtl/ptmch_sync_bit.sv | 29 ++
 rtl/ptmch_spi_rx.sv | 207 ++++++++++++++++++++
 tb/tb_ptmch_spi_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ptmch_pkg.sv
// Shared types and defaults for the pattern-match trigger SPI front end.
//   spi_rx_st_t     receiver FSM state encoding
//   SPI_WORD_W_DEF  default received word width
//   cs_level_on()   maps a raw chip-select level to "selected" for either polarity
package ptmch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_st_t;

  localparam int unsigned SPI_WORD_W_DEF   = 16;
  localparam int unsigned SPI_SYNC_STG_DEF = 2;

  // True when the chip-select level means "slave selected".
  function automatic logic cs_level_on(input logic cs, input logic act_low);
    return act_low ? ~cs : cs;
  endfunction

endpackage

// File: rtl/ptmch_sync_bit.sv
// N-stage synchroniser for one asynchronous input bit.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset; all stages load P_RST_VAL
//   d      asynchronous input
//   q      synchronised output (last stage)
module ptmch_sync_bit #(
  parameter int unsigned P_STAGES  = 2,
  parameter logic        P_RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [P_STAGES-1:0] stg;

  // Plain shift chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= {P_STAGES{P_RST_VAL}};
    end else begin
      stg <= {stg[P_STAGES-2:0], d};
    end
  end

  assign q = stg[P_STAGES-1];

endmodule

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave receiver, oversampled in the CLK160M domain.
// Deserialises each chip-select frame into P_WORD_W-bit words and flags
// frames released with a partial word pending.
//   CLK160M     system clock (sole clock)
//   RESET_N     asynchronous active-low reset
//   SPI_CS      chip select (async), polarity per P_CS_ACT_LOW
//   SPI_CLK     SPI clock (async), sampled on its rising edge
//   SPI_MOSI    SPI data (async)
//   RX_DATA     last completed word, held until the next completion
//   RX_VALID    one-cycle strobe: RX_DATA updated
//   RX_SOF      with RX_VALID: word is the first of its frame
//   RX_FRM_ERR  one-cycle strobe: frame ended with 1..P_WORD_W-1 bits pending
//   RX_BUSY     high while the receiver is in SHIFT
module ptmch_spi_rx
  import ptmch_pkg::*;
#(
  parameter int unsigned P_WORD_W     = SPI_WORD_W_DEF,
  parameter int unsigned P_SYNC_STG   = SPI_SYNC_STG_DEF,
  parameter bit          P_CS_ACT_LOW = 1'b1,
  parameter bit          P_MSB_FIRST  = 1'b1
) (
  input  logic                CLK160M,
  input  logic                RESET_N,
  input  logic                SPI_CS,
  input  logic                SPI_CLK,
  input  logic                SPI_MOSI,
  output logic [P_WORD_W-1:0] RX_DATA,
  output logic                RX_VALID,
  output logic                RX_SOF,
  output logic                RX_FRM_ERR,
  output logic                RX_BUSY
);

  localparam int unsigned      CNT_W       = (P_WORD_W > 1) ? $clog2(P_WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(P_WORD_W - 1);
  localparam logic             CS_IDLE_LVL = P_CS_ACT_LOW ? 1'b1 : 1'b0;
  localparam int unsigned      WARM_W      = P_SYNC_STG + 1;

  // Synchronised inputs and edge-detect history
  logic cs_s;
  logic sck_s;
  logic mosi_s;
  logic sck_d;
  logic cs_d;

  logic cs_on;
  logic cs_d_on;
  logic sck_rise;

  // Receiver state
  spi_rx_st_t          state;
  spi_rx_st_t          state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [P_WORD_W-1:0] sr;
  logic [P_WORD_W-1:0] sr_nxt;
  logic [P_WORD_W-1:0] sr_shift;
  logic                first_word;
  logic                first_nxt;
  logic [WARM_W-1:0]   warm;
  logic                armed;
  logic                armed_nxt;

  // Next output values
  logic [P_WORD_W-1:0] data_nxt;
  logic                valid_nxt;
  logic                sof_nxt;
  logic                err_nxt;

  // Equal-depth synchronisers keep CS/SCK/MOSI mutually aligned.
  ptmch_sync_bit #(
    .P_STAGES  (P_SYNC_STG),
    .P_RST_VAL (CS_IDLE_LVL)
  ) u_sync_cs (
    .clk   (CLK160M),
    .rst_n (RESET_N),
    .d     (SPI_CS),
    .q     (cs_s)
  );

  ptmch_sync_bit #(
    .P_STAGES  (P_SYNC_STG),
    .P_RST_VAL (1'b0)
  ) u_sync_sck (
    .clk   (CLK160M),
    .rst_n (RESET_N),
    .d     (SPI_CLK),
    .q     (sck_s)
  );

  ptmch_sync_bit #(
    .P_STAGES  (P_SYNC_STG),
    .P_RST_VAL (1'b0)
  ) u_sync_mosi (
    .clk   (CLK160M),
    .rst_n (RESET_N),
    .d     (SPI_MOSI),
    .q     (mosi_s)
  );

  // History flops for edge detection
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      sck_d <= 1'b0;
      cs_d  <= CS_IDLE_LVL;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign cs_on    = cs_level_on(cs_s, P_CS_ACT_LOW);
  assign cs_d_on  = cs_level_on(cs_d, P_CS_ACT_LOW);
  assign sck_rise = sck_s & ~sck_d;

  // Next shift-register value for the current MOSI sample
  assign sr_shift = P_MSB_FIRST ? {sr[P_WORD_W-2:0], mosi_s}
                                : {mosi_s, sr[P_WORD_W-1:1]};

  // Marks when the CS history flop holds a genuine post-reset sample rather
  // than the reset level, so a frame in flight at reset cannot be joined.
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      warm <= '0;
    end else begin
      warm <= {warm[WARM_W-2:0], 1'b1};
    end
  end

  // State register and registered outputs
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      first_word <= 1'b0;
      armed      <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      RX_SOF     <= 1'b0;
      RX_FRM_ERR <= 1'b0;
      RX_BUSY    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sr         <= sr_nxt;
      first_word <= first_nxt;
      armed      <= armed_nxt;
      RX_DATA    <= data_nxt;
      RX_VALID   <= valid_nxt;
      RX_SOF     <= sof_nxt;
      RX_FRM_ERR <= err_nxt;
      RX_BUSY    <= (state_nxt == SHIFT);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    first_nxt = first_word;
    data_nxt  = RX_DATA;
    valid_nxt = 1'b0;
    sof_nxt   = 1'b0;
    err_nxt   = 1'b0;
    armed_nxt = armed | (warm[WARM_W-1] & ~cs_d_on);

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        sr_nxt  = '0;
        if (cs_on && armed) begin
          state_nxt = SHIFT;
          first_nxt = 1'b1;
        end
      end

      SHIFT: begin
        // An edge coincident with CS release is consumed before the exit.
        if (sck_rise) begin
          sr_nxt = sr_shift;
          if (cnt == CNT_LAST) begin
            data_nxt  = sr_shift;
            valid_nxt = 1'b1;
            sof_nxt   = first_word;
            first_nxt = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        if (!cs_on) begin
          state_nxt = IDLE;
          err_nxt   = (cnt_nxt != '0);
          cnt_nxt   = '0;
          sr_nxt    = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ptmch_spi_rx.sv
`timescale 1ns/1ps
module tb_ptmch_spi_rx;

  localparam int unsigned W    = 16;
  localparam int unsigned SYNC = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs    = 1'b1;
  logic         sck   = 1'b0;
  logic         mosi  = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_sof;
  logic         rx_frm_err;
  logic         rx_busy;

  ptmch_spi_rx #(
    .P_WORD_W     (W),
    .P_SYNC_STG   (SYNC),
    .P_CS_ACT_LOW (1'b1),
    .P_MSB_FIRST  (1'b1)
  ) dut (
    .CLK160M    (clk),
    .RESET_N    (rst_n),
    .SPI_CS     (cs),
    .SPI_CLK    (sck),
    .SPI_MOSI   (mosi),
    .RX_DATA    (rx_data),
    .RX_VALID   (rx_valid),
    .RX_SOF     (rx_sof),
    .RX_FRM_ERR (rx_frm_err),
    .RX_BUSY    (rx_busy)
  );

  always #3.125 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;
  int err_seen  = 0;
  int last_rise = 0;
  int e0;
  int lat;
  logic [W:0] exp_q[$];   // {sof, data}
  int         vtime_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, input int half);
    mosi = b;
    tick(half);
    sck = 1'b1;
    last_rise = cyc;
    tick(half);
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int half, input logic sof);
    exp_q.push_back({sof, w});
    for (int i = W - 1; i >= 0; i--) spi_bit(w[i], half);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rx_data, rx_valid, rx_sof, rx_frm_err, rx_busy});
  endfunction

  initial begin
    fork
      begin : mon
        logic [W:0] e;
        forever begin
          @(negedge clk);
          if (rx_valid || rx_frm_err)
            check("valid_err_excl", 32'(rx_valid & rx_frm_err), 32'd0);
          if (rx_frm_err) err_seen++;
          if (rx_valid) begin
            vtime_q.push_back(cyc);
            if (exp_q.size() == 0) begin
              check("unexpected_valid", 32'(rx_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("rx_data", 32'(rx_data), 32'(e[W-1:0]));
              check("rx_sof", 32'(rx_sof), 32'(e[W]));
            end
          end
        end
      end
      begin : watchdog
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    // 1: reset with SPI lines toggling
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) begin
        cs   = 1'($urandom_range(1));
        sck  = 1'($urandom_range(1));
        mosi = 1'($urandom_range(1));
        tick(1);
      end
      check("reset_outs", all_outs(), 32'd0);
    end
    cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    check("idle_after_reset", all_outs(), 32'd0);

    // 2: single word at 10 MHz
    e0 = err_seen;
    vtime_q.delete();
    cs = 1'b0;
    tick(8);
    check("busy_in_frame", 32'(rx_busy), 32'd1);
    send_word(16'hA5C3, 8, 1'b1);
    tick(8);
    cs = 1'b1;
    tick(8);
    drain();
    check("busy_after_frame", 32'(rx_busy), 32'd0);
    check("single_err", 32'(err_seen - e0), 32'd0);
    check("single_count", 32'(vtime_q.size()), 32'd1);
    if (vtime_q.size() > 0) begin
      lat = vtime_q[0] - last_rise;
      check("latency_range", 32'((lat >= int'(SYNC) + 1) && (lat <= int'(SYNC) + 3)), 32'd1);
    end

    // 3: back-to-back words at 20 MHz
    e0 = err_seen;
    vtime_q.delete();
    cs = 1'b0;
    tick(8);
    send_word(16'h1234, 4, 1'b1);
    send_word(16'hFFFF, 4, 1'b0);
    tick(4);
    cs = 1'b1;
    tick(8);
    drain();
    check("b2b_count", 32'(vtime_q.size()), 32'd2);
    if (vtime_q.size() == 2)
      check("b2b_spacing", 32'(vtime_q[1] - vtime_q[0]), 32'd128);
    check("b2b_hold", 32'(rx_data), 32'hFFFF);
    check("b2b_err", 32'(err_seen - e0), 32'd0);

    // 4: truncated frame, 5 bits 10110
    e0 = err_seen;
    vtime_q.delete();
    cs = 1'b0;
    tick(8);
    spi_bit(1'b1, 8);
    spi_bit(1'b0, 8);
    spi_bit(1'b1, 8);
    spi_bit(1'b1, 8);
    spi_bit(1'b0, 8);
    tick(8);
    cs = 1'b1;
    tick(12);
    check("trunc_err", 32'(err_seen - e0), 32'd1);
    check("trunc_no_valid", 32'(vtime_q.size()), 32'd0);
    check("trunc_hold", 32'(rx_data), 32'hFFFF);
    check("trunc_busy", 32'(rx_busy), 32'd0);

    // 5a: last SCK rise coincident with CS release
    begin
      logic [W-1:0] w;
      w = 16'h5A5A;
      e0 = err_seen;
      vtime_q.delete();
      cs = 1'b0;
      tick(8);
      exp_q.push_back({1'b1, w});
      for (int i = W - 1; i >= 1; i--) spi_bit(w[i], 8);
      mosi = w[0];
      tick(8);
      sck = 1'b1;
      cs  = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(8);
      drain();
      check("corner_count", 32'(vtime_q.size()), 32'd1);
      check("corner_err", 32'(err_seen - e0), 32'd0);
    end

    // 5b: SCK activity with CS inactive
    e0 = err_seen;
    vtime_q.delete();
    for (int i = 0; i < 16; i++) begin
      spi_bit(1'($urandom_range(1)), 4);
      if (i == 7) check("nocs_busy_mid", 32'(rx_busy), 32'd0);
    end
    tick(8);
    check("nocs_busy", 32'(rx_busy), 32'd0);
    check("nocs_err", 32'(err_seen - e0), 32'd0);
    check("nocs_valid", 32'(vtime_q.size()), 32'd0);

    // 6: reset mid-frame, then a clean frame
    e0 = err_seen;
    vtime_q.delete();
    cs = 1'b0;
    tick(8);
    for (int i = 7; i >= 0; i--) spi_bit(1'(8'hC3 >> i), 8);
    rst_n = 1'b0;
    tick(3);
    check("midrst_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, 8);
    check("midrst_not_rearmed", 32'(rx_busy), 32'd0);
    cs = 1'b1;
    tick(8);
    check("midrst_no_valid", 32'(vtime_q.size()), 32'd0);
    check("midrst_err", 32'(err_seen - e0), 32'd0);
    cs = 1'b0;
    tick(8);
    send_word(16'h00FF, 8, 1'b1);
    tick(8);
    cs = 1'b1;
    tick(8);
    drain();
    check("postrst_data", 32'(rx_data), 32'h00FF);
    check("postrst_count", 32'(vtime_q.size()), 32'd1);

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
